// File: rtl/daq_pingpong_buf_pkg.sv
// Shared types and sizing helpers for the ping-pong acquisition buffer.
package daq_buf_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StStall} wr_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned bytes_per_sample(input int unsigned sample_w,
                                                   input int unsigned out_w);
    return sample_w / out_w;
  endfunction

  function automatic int unsigned frame_w(input int unsigned ch_num, input int unsigned sample_w);
    return ch_num * sample_w;
  endfunction

  function automatic int unsigned bank_bytes(input int unsigned depth, input int unsigned ch_num,
                                             input int unsigned sample_w, input int unsigned out_w);
    return depth * ch_num * bytes_per_sample(sample_w, out_w);
  endfunction

  function automatic int unsigned rd_aw(input int unsigned depth, input int unsigned ch_num,
                                        input int unsigned sample_w, input int unsigned out_w);
    return clog2(bank_bytes(depth, ch_num, sample_w, out_w));
  endfunction

endpackage

// File: rtl/daq_pingpong_buf_if.sv
// Acquisition-side and reader-side signals of the ping-pong buffer.
interface daq_pingpong_buf_if #(
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned OUT_W    = 8
);
  import daq_buf_pkg::*;

  localparam int unsigned RD_AW = rd_aw(DEPTH, CH_NUM, SAMPLE_W, OUT_W);

  logic                         acq_en;
  logic [CH_NUM*SAMPLE_W-1:0]   smp_data;
  logic                         smp_valid;
  logic [RD_AW-1:0]             rd_addr;
  logic [OUT_W-1:0]             rd_data;
  logic                         bank_rdy;
  logic                         send_go;
  logic                         rd_done;
  logic                         overflow;
  logic [15:0]                  ovf_cnt;

  modport master (
    output acq_en, smp_data, smp_valid, rd_addr, rd_done,
    input  rd_data, bank_rdy, send_go, overflow, ovf_cnt
  );

  modport slave (
    input  acq_en, smp_data, smp_valid, rd_addr, rd_done,
    output rd_data, bank_rdy, send_go, overflow, ovf_cnt
  );

endinterface

// File: rtl/daq_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module daq_sdp_ram #(
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = 11
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [2**AddrW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/daq_pingpong_buf.sv
// Ping-pong acquisition buffer: frames fill one bank while the other is read byte-wise.
// Dropped-frame counter is built only when DAQ_PINGPONG_BUF_OVF_CNT_EN is defined.
module daq_pingpong_buf #(
  parameter int unsigned CH_NUM   = 2,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned OUT_W    = 8
) (
  input logic               sysclk,
  input logic               rst,
  daq_pingpong_buf_if.slave bus
);
  import daq_buf_pkg::*;

  localparam int unsigned FrameW     = frame_w(CH_NUM, SAMPLE_W);
  localparam int unsigned FrameBytes = CH_NUM * bytes_per_sample(SAMPLE_W, OUT_W);
  localparam int unsigned RdAw       = rd_aw(DEPTH, CH_NUM, SAMPLE_W, OUT_W);
  localparam int unsigned FrmAw      = clog2(DEPTH);
  localparam int unsigned SelW       = (FrameBytes > 1) ? clog2(FrameBytes) : 1;

  wr_state_e        state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [FrmAw-1:0] wr_frm_q, wr_frm_d;
  logic             send_go_q, overflow_q, overflow_d;
  logic             we, bank_done, rd_release;

  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_frm_d   = wr_frm_q;
    we         = 1'b0;
    bank_done  = 1'b0;
    overflow_d = 1'b0;
    rd_release = bus.rd_done && full_q[rd_bank_q];

    unique case (state_q)
      StIdle: if (bus.acq_en) state_d = StFill;
      StFill, StStall: begin
        if (bus.smp_valid && full_q[wr_bank_q]) begin
          overflow_d = 1'b1;
          state_d    = StStall;
        end else begin
          if (bus.smp_valid) begin
            we       = 1'b1;
            wr_frm_d = wr_frm_q + 1'b1;
            if (wr_frm_q == FrmAw'(DEPTH - 1)) begin
              bank_done = 1'b1;
              wr_bank_d = ~wr_bank_q;
            end
          end
          if (!full_q[wr_bank_q]) state_d = StFill;
        end
        // A completing write still lands before dropping back to idle.
        if (!bus.acq_en) begin
          state_d  = StIdle;
          wr_frm_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Set and clear always hit different banks: the writer never fills a full bank.
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (bank_done) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= StIdle;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_frm_q   <= '0;
      send_go_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_frm_q   <= wr_frm_d;
      send_go_q  <= bank_done;
      overflow_q <= overflow_d;
    end
  end

  logic [FrmAw:0]    waddr, raddr;
  logic [FrameW-1:0] rdata;
  logic [SelW-1:0]   sel_q;
  logic [OUT_W-1:0]  rd_data_q;

  // Bank bit is the RAM address MSB.
  assign waddr = {wr_bank_q, wr_frm_q};
  assign raddr = {rd_bank_q, FrmAw'(bus.rd_addr / RdAw'(FrameBytes))};

  daq_sdp_ram #(
    .Width (FrameW),
    .AddrW (FrmAw + 1)
  ) u_ram (
    .clk   (sysclk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.smp_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge sysclk) begin
    sel_q <= SelW'(bus.rd_addr % RdAw'(FrameBytes));
  end

  always_ff @(posedge sysclk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rdata[sel_q * OUT_W +: OUT_W];
  end

`ifdef DAQ_PINGPONG_BUF_OVF_CNT_EN
  logic        acq_en_q;
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      acq_en_q  <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      acq_en_q <= bus.acq_en;
      if (bus.acq_en && !acq_en_q)                 ovf_cnt_q <= '0;
      else if (overflow_d && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`else
  assign bus.ovf_cnt = 16'h0000;
`endif

  assign bus.rd_data  = rd_data_q;
  assign bus.bank_rdy = full_q[rd_bank_q];
  assign bus.send_go  = send_go_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_daq_pingpong_buf.sv
// Bench for daq_pingpong_buf: default-size directed sequences plus a small
// 4ch x 24b x 16 instance with a read table and a randomized reference model.
module tb_daq_pingpong_buf;
  import daq_buf_pkg::*;

`ifdef DAQ_PINGPONG_BUF_OVF_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } rd_vec_t;

  logic sysclk = 1'b0;
  logic rst_d  = 1'b1;
  logic rst_s  = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 sysclk = ~sysclk;

  daq_pingpong_buf_if ifd ();
  daq_pingpong_buf_if #(.CH_NUM(4), .SAMPLE_W(24), .DEPTH(16), .OUT_W(8)) ifs ();

  daq_pingpong_buf dut_d (.sysclk(sysclk), .rst(rst_d), .bus(ifd.slave));
  daq_pingpong_buf #(
    .CH_NUM(4), .SAMPLE_W(24), .DEPTH(16), .OUT_W(8)
  ) dut_s (.sysclk(sysclk), .rst(rst_s), .bus(ifs.slave));

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    return CntEn ? ((n > 65535) ? 16'hFFFF : 16'(n)) : 16'h0000;
  endfunction

  // Default instance: ch0 = index + off, ch1 = its complement.
  function automatic logic [31:0] d_frame(input int f, input logic [15:0] off);
    logic [15:0] v;
    v = 16'(f) + off;
    return {~v, v};
  endfunction

  function automatic logic [7:0] d_byte(input int a, input logic [15:0] off);
    return 8'(d_frame(a / 4, off) >> (8 * (a % 4)));
  endfunction

  // Small instance table pattern: each 24-bit sample = {16*ch+f, A5, f+ch}.
  function automatic logic [95:0] s_frame(input int f);
    logic [95:0] w;
    for (int c = 0; c < 4; c++) w[c*24 +: 24] = {8'(16 * c + f), 8'hA5, 8'(f + c)};
    return w;
  endfunction

  task automatic d_reset();
    rst_d = 1'b1;
    ifd.acq_en = 1'b0; ifd.smp_valid = 1'b0; ifd.rd_done = 1'b0; ifd.rd_addr = '0;
    tick(); tick();
    rst_d = 1'b0;
  endtask

  task automatic d_fill(input int first, input int n, input logic [15:0] off,
                        output int go, output int ov);
    go = 0; ov = 0;
    for (int i = first; i < first + n; i++) begin
      ifd.smp_valid = 1'b1;
      ifd.smp_data  = d_frame(i, off);
      tick();
      go += int'(ifd.send_go);
      ov += int'(ifd.overflow);
    end
    ifd.smp_valid = 1'b0;
  endtask

  task automatic d_read(input int a, output logic [7:0] q);
    ifd.rd_addr = 12'(a);
    tick(); tick();
    q = ifd.rd_data;
  endtask

  task automatic s_read(input logic [7:0] a, output logic [7:0] q);
    ifs.rd_addr = a;
    tick(); tick();
    q = ifs.rd_data;
  endtask

  task automatic s_fill16();
    for (int f = 0; f < 16; f++) begin
      ifs.smp_valid = 1'b1;
      ifs.smp_data  = s_frame(f);
      tick();
    end
    ifs.smp_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd_vec_t    tbl [11];
    int         go, ov;
    logic [7:0] q;

    tbl[0]  = '{8'd0,   8'h00};
    tbl[1]  = '{8'd1,   8'hA5};
    tbl[2]  = '{8'd2,   8'h00};
    tbl[3]  = '{8'd3,   8'h01};
    tbl[4]  = '{8'd11,  8'h30};
    tbl[5]  = '{8'd12,  8'h01};
    tbl[6]  = '{8'd44,  8'h23};
    tbl[7]  = '{8'd101, 8'h18};
    tbl[8]  = '{8'd120, 8'h0A};
    tbl[9]  = '{8'd189, 8'h12};
    tbl[10] = '{8'd191, 8'h3F};

    ifs.acq_en = 1'b0; ifs.smp_valid = 1'b0; ifs.rd_done = 1'b0;
    ifs.rd_addr = '0; ifs.smp_data = '0; ifd.smp_data = '0;

    // Reset values and one full bank with send_go timing.
    d_reset();
    chk("rst_rd_data", 64'(ifd.rd_data), 64'(0));
    chk("rst_bank_rdy", 64'(ifd.bank_rdy), 64'(0));
    chk("rst_send_go", 64'(ifd.send_go), 64'(0));
    chk("rst_overflow", 64'(ifd.overflow), 64'(0));
    chk("rst_ovf_cnt", 64'(ifd.ovf_cnt), 64'(0));
    ifd.acq_en = 1'b1;
    tick();
    d_fill(0, 1023, 16'h0000, go, ov);
    chk("t1_go_early", 64'(go), 64'(0));
    chk("t1_rdy_early", 64'(ifd.bank_rdy), 64'(0));
    d_fill(1023, 1, 16'h0000, go, ov);
    chk("t1_send_go", 64'(ifd.send_go), 64'(1));
    chk("t1_bank_rdy", 64'(ifd.bank_rdy), 64'(1));
    tick();
    chk("t1_send_go_pulse", 64'(ifd.send_go), 64'(0));
    for (int a = 0; a < 4097; a++) begin
      if (a < 4096) ifd.rd_addr = 12'(a);
      tick();
      if (a >= 1) chk("t1_rd_data", 64'(ifd.rd_data), 64'(d_byte(a - 1, 16'h0000)));
    end

    // Second bank then three dropped frames.
    d_fill(0, 1024, 16'h8000, go, ov);
    chk("t2_go", 64'(go), 64'(1));
    d_fill(1024, 3, 16'h8000, go, ov);
    tick();
    chk("t2_ovf_pulses", 64'(ov), 64'(3));
    chk("t2_ovf_idle", 64'(ifd.overflow), 64'(0));
    chk("t2_ovf_cnt", 64'(ifd.ovf_cnt), 64'(exp_cnt(3)));
    chk("t2_bank_rdy", 64'(ifd.bank_rdy), 64'(1));
    foreach (tbl[i]) begin
      d_read(int'(tbl[i].addr) * 21, q);
      chk("t2_bank0_intact", 64'(q), 64'(d_byte(int'(tbl[i].addr) * 21, 16'h0000)));
    end

    // Release of bank 0 on the same edge as the last write of bank 1.
    d_reset();
    ifd.acq_en = 1'b1;
    tick();
    d_fill(0, 1024, 16'h1000, go, ov);
    d_fill(0, 1023, 16'h2000, go, ov);
    ifd.smp_valid = 1'b1; ifd.smp_data = d_frame(1023, 16'h2000); ifd.rd_done = 1'b1;
    tick();
    ifd.smp_valid = 1'b0; ifd.rd_done = 1'b0;
    chk("t3_bank_rdy", 64'(ifd.bank_rdy), 64'(1));
    chk("t3_send_go", 64'(ifd.send_go), 64'(1));
    d_fill(0, 1, 16'h3000, go, ov);
    chk("t3_no_drop", 64'(ifd.overflow), 64'(0));
    d_read(1, q);
    chk("t3_reads_bank1", 64'(q), 64'(8'h20));
    ifd.rd_done = 1'b1;
    tick();
    ifd.rd_done = 1'b0;
    chk("t3_bank0_not_full", 64'(ifd.bank_rdy), 64'(0));
    d_read(1, q);
    chk("t3_new_in_bank0", 64'(q), 64'(8'h30));
    d_read(5, q);
    chk("t3_old_in_bank0", 64'(q), 64'(8'h10));

    // Abandoned partial bank restarts from frame 0.
    d_reset();
    ifd.acq_en = 1'b1;
    tick();
    d_fill(0, 500, 16'h4000, go, ov);
    ifd.acq_en = 1'b0;
    tick(); tick();
    ifd.acq_en = 1'b1;
    tick();
    d_fill(0, 1023, 16'h6000, go, ov);
    chk("t4_go_early", 64'(go), 64'(0));
    chk("t4_rdy_early", 64'(ifd.bank_rdy), 64'(0));
    d_fill(1023, 1, 16'h6000, go, ov);
    chk("t4_send_go", 64'(ifd.send_go), 64'(1));
    d_read(1, q);
    chk("t4_frame0", 64'(q), 64'(8'h60));
    d_read(4 * 499 + 1, q);
    chk("t4_frame499", 64'(q), 64'(8'h61));
    d_read(4 * 600 + 2, q);
    chk("t4_frame600_ch1", 64'(q), 64'(d_byte(4 * 600 + 2, 16'h6000)));

    // Small instance: byte-order table.
    rst_s = 1'b1;
    tick(); tick();
    rst_s = 1'b0;
    chk("s_rst_bank_rdy", 64'(ifs.bank_rdy), 64'(0));
    ifs.acq_en = 1'b1;
    tick();
    s_fill16();
    chk("s_bank_rdy", 64'(ifs.bank_rdy), 64'(1));
    for (int i = 0; i < 11; i++) begin
      s_read(tbl[i].addr, q);
      chk("s_table", 64'(q), 64'(tbl[i].data));
    end

    // Reset mid-read, then an ignored rd_done.
    ifs.rd_addr = 8'd44;
    tick();
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    chk("s_rst_mid_read", 64'(ifs.bank_rdy), 64'(0));
    ifs.rd_done = 1'b1;
    tick();
    ifs.rd_done = 1'b0;
    s_fill16();
    chk("s_rd_bank_kept", 64'(ifs.bank_rdy), 64'(1));
    chk("s_send_go", 64'(ifs.send_go), 64'(1));

    // Randomized traffic against a bank-level reference model.
    rst_s = 1'b1;
    ifs.acq_en = 1'b0;
    tick(); tick();
    rst_s = 1'b0;
    ifs.acq_en = 1'b1;
    tick(); tick();
    begin
      logic [95:0] mm [2][16];
      logic [1:0]  full;
      int          wb, wf, rb, drops;
      logic        pv;
      logic [7:0]  pe;
      full = 2'b00; wb = 0; wf = 0; rb = 0; drops = 0; pv = 1'b0; pe = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic        v, dn, cv, eg, eo;
        logic [95:0] dat;
        logic [1:0]  pre;
        logic [7:0]  ce;
        int          a;
        v   = ($urandom_range(0, 9) < 6);
        dn  = ($urandom_range(0, 11) == 0);
        dat = {$urandom, $urandom, $urandom};
        a   = int'($urandom_range(0, 191));
        ifs.smp_valid = v; ifs.smp_data = dat; ifs.rd_done = dn; ifs.rd_addr = 8'(a);
        pre = full;
        cv  = pre[rb];
        ce  = 8'(mm[rb][a / 12] >> (8 * (a % 12)));
        eg  = 1'b0;
        eo  = 1'b0;
        if (v && pre[wb]) begin
          eo = 1'b1;
          drops++;
        end else if (v) begin
          mm[wb][wf] = dat;
          wf++;
          if (wf == 16) begin
            wf = 0; full[wb] = 1'b1; wb ^= 1; eg = 1'b1;
          end
        end
        if (dn && pre[rb]) begin
          full[rb] = 1'b0;
          rb ^= 1;
        end
        tick();
        chk("rnd_send_go", 64'(ifs.send_go), 64'(eg));
        chk("rnd_overflow", 64'(ifs.overflow), 64'(eo));
        chk("rnd_bank_rdy", 64'(ifs.bank_rdy), 64'(full[rb]));
        chk("rnd_ovf_cnt", 64'(ifs.ovf_cnt), 64'(exp_cnt(drops)));
        if (pv) chk("rnd_rd_data", 64'(ifs.rd_data), 64'(pe));
        pv = cv;
        pe = ce;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
